// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-requester byte arbiter feeding one UART serializer, with a
//               per-requester FIFO and a newline-delimited line lock.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DEPTH        = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       ser_we,
    output logic [7:0] ser_data,
    input  logic       ser_ready,
    output logic       owner,
    output logic       locked,
    output logic       busy
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam int               c_TMR_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_PTR_W:0] c_FULL  = DEPTH[c_PTR_W:0];
    localparam logic [c_TMR_W-1:0] c_TIMEOUT = LOCK_TIMEOUT[c_TMR_W-1:0];
    localparam logic [7:0]       c_NEWLINE = 8'h0A;

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_WAIT_ACK  = 2'd1;
    localparam logic [1:0] c_S_WAIT_DONE = 2'd2;

    logic [1:0]         r_state,    w_state_nxt;
    logic               r_ser_we,   w_ser_we_nxt;
    logic [7:0]         r_ser_data, w_ser_data_nxt;
    logic               r_owner,    w_owner_nxt;
    logic               r_locked,   w_locked_nxt;
    logic [c_TMR_W-1:0] r_timer,    w_timer_nxt;
    logic [c_TMR_W-1:0] w_timer_inc;

    logic [1:0] w_in_valid;
    logic [7:0] w_in_data [2];
    logic [7:0] w_head    [2];
    logic [1:0] w_push, w_pop, w_nempty, w_full, w_ready;
    logic       w_sel_valid, w_sel_id, w_lock_idle;
    logic [7:0] w_sel_byte;

    assign w_in_valid   = {req1_valid, req0_valid};
    assign w_in_data[0] = req0_data;
    assign w_in_data[1] = req1_data;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [7:0]         r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
            logic [c_PTR_W:0]   r_count;

            assign w_full[g]   = (r_count == c_FULL);
            assign w_nempty[g] = (r_count != '0);
            // Ready is forced low during reset so nothing is accepted then.
            assign w_ready[g]  = ~rst & ~w_full[g];
            assign w_push[g]   = w_in_valid[g] & w_ready[g];
            assign w_head[g]   = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (w_push[g]) begin
                    r_mem[r_wr_ptr] <= w_in_data[g];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[g])  r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({w_push[g], w_pop[g]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // A held lock only ever grants the owner; otherwise round-robin.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = r_owner;
        if (r_state == c_S_IDLE && ser_ready) begin
            if (r_locked) begin
                w_sel_valid = w_nempty[r_owner];
            end else if (w_nempty[0] ^ w_nempty[1]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = w_nempty[1];
            end else if (&w_nempty) begin
                w_sel_valid = 1'b1;
                w_sel_id    = ~r_owner;
            end
        end
    end

    assign w_sel_byte  = w_head[w_sel_id];
    assign w_pop       = w_sel_valid ? (w_sel_id ? 2'b10 : 2'b01) : 2'b00;
    assign w_lock_idle = (r_state == c_S_IDLE) & r_locked & ~w_nempty[r_owner];
    assign w_timer_inc = (r_timer == c_TIMEOUT) ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_ser_we_nxt   = r_ser_we;
        w_ser_data_nxt = r_ser_data;
        w_owner_nxt    = r_owner;
        w_locked_nxt   = r_locked;
        w_timer_nxt    = r_timer;
        case (r_state)
            c_S_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt    = c_S_WAIT_ACK;
                    w_ser_we_nxt   = 1'b1;
                    w_ser_data_nxt = w_sel_byte;
                    w_owner_nxt    = w_sel_id;
                    w_locked_nxt   = (w_sel_byte != c_NEWLINE);
                end
            end
            c_S_WAIT_ACK: begin
                if (!ser_ready) begin
                    w_state_nxt  = c_S_WAIT_DONE;
                    w_ser_we_nxt = 1'b0;
                end
            end
            c_S_WAIT_DONE: begin
                if (ser_ready) w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt  = c_S_IDLE;
                w_ser_we_nxt = 1'b0;
            end
        endcase
        if (w_sel_valid || !r_locked) begin
            w_timer_nxt = '0;
        end else if (w_lock_idle) begin
            w_timer_nxt = w_timer_inc;
            if (w_timer_inc == c_TIMEOUT) w_locked_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_ser_we   <= 1'b0;
            r_ser_data <= 8'h00;
            r_owner    <= 1'b0;
            r_locked   <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ser_we   <= w_ser_we_nxt;
            r_ser_data <= w_ser_data_nxt;
            r_owner    <= w_owner_nxt;
            r_locked   <= w_locked_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign ser_we     = r_ser_we;
    assign ser_data   = r_ser_data;
    assign owner      = r_owner;
    assign locked     = r_locked;
    assign busy       = (r_state != c_S_IDLE) | (|w_nempty);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with a serializer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       ser_we;
    logic [7:0] ser_data;
    logic       ser_ready = 1'b0;
    logic       owner, locked, busy;

    logic       r_hold = 1'b1;
    int         r_ser_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [9:0] sb [$];   // {owner, locked, byte}

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(4), .LOCK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_we(ser_we), .ser_data(ser_data), .ser_ready(ser_ready),
        .owner(owner), .locked(locked), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Serializer: accepts a write when idle, then stays busy for 3 cycles.
    always @(negedge clk) begin
        logic [9:0] exp;
        if (ser_ready && ser_we) begin
            if (sb.size() == 0) begin
                check_val("sb_extra_byte", 32'(ser_data), 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                check_val("ser_byte", 32'({owner, locked, ser_data}), 32'(exp));
            end
            r_ser_cnt = 3;
        end else if (r_ser_cnt != 0) begin
            r_ser_cnt = r_ser_cnt - 1;
        end
        ser_ready = !r_hold && (r_ser_cnt == 0);
    end

    task automatic push(input bit id, input logic [7:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (((id ? req1_ready : req0_ready) == 1'b0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_val("push_timeout", 32'(guard), 0);
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !ser_ready) && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, "_drain"}, 32'(sb.size()), 0);
        check_val({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int first;
        int guard;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ser_we", 32'(ser_we), 0);
        check_val("rst_ser_data", 32'(ser_data), 0);
        check_val("rst_owner", 32'(owner), 0);
        check_val("rst_locked", 32'(locked), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_ready", 32'({req1_ready, req0_ready}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_ready", 32'({req1_ready, req0_ready}), 32'h3);

        // Single byte
        r_hold = 1'b0;
        do_reset();
        sb.push_back({1'b0, 1'b1, 8'h41});
        push(1'b0, 8'h41);
        @(posedge clk);
        #1;
        check_val("single_we", 32'(ser_we), 1);
        check_val("single_data", 32'(ser_data), 32'h41);
        check_val("single_lock", 32'({owner, locked}), 32'h1);
        @(posedge clk);
        #1;
        check_val("single_we_drop", 32'(ser_we), 0);
        drain("single");

        // Line lock: A B \n on req0 must finish before x y on req1
        do_reset();
        sb.push_back({1'b0, 1'b1, 8'h41});
        push(1'b0, 8'h41);
        @(posedge clk);
        #1 r_hold = 1'b1;
        check_val("lock_first_we", 32'(ser_we), 1);
        sb.push_back({1'b0, 1'b1, 8'h42});
        sb.push_back({1'b0, 1'b0, 8'h0A});
        sb.push_back({1'b1, 1'b1, 8'h78});
        sb.push_back({1'b1, 1'b1, 8'h79});
        push(1'b0, 8'h42);
        push(1'b0, 8'h0A);
        push(1'b1, 8'h78);
        push(1'b1, 8'h79);
        @(posedge clk);
        #1 r_hold = 1'b0;
        drain("lock");

        // Round-robin with newline bytes only
        r_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 8'h0A);
            push(1'b1, 8'h0A);
        end
        for (int i = 0; i < 2; i++) begin
            sb.push_back({1'b1, 1'b0, 8'h0A});
            sb.push_back({1'b0, 1'b0, 8'h0A});
        end
        @(posedge clk);
        #1 r_hold = 1'b0;
        drain("rr");

        // Lock timeout: req1 waits for the timer after req0 goes quiet
        do_reset();
        sb.push_back({1'b0, 1'b1, 8'h41});
        push(1'b0, 8'h41);
        @(posedge clk);
        #1 r_hold = 1'b1;
        sb.push_back({1'b1, 1'b1, 8'h7A});
        push(1'b1, 8'h7A);
        @(posedge clk);
        #1 r_hold = 1'b0;
        first = 0;
        guard = 0;
        @(posedge clk);
        while (!ser_ready && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(posedge clk);
            #1;
            if (i == 8) check_val("to_locked_before", 32'(locked), 1);
            if (i == 9) check_val("to_locked_after", 32'(locked), 0);
            if (ser_we && first == 0) first = i;
            if (first != 0) break;
        end
        check_val("to_issue_cycle", 32'(first), 10);
        drain("timeout");

        // Full FIFO and push during pop
        r_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b1, 1'b1, 8'(8'hC1 + i)});
            push(1'b1, 8'(8'hC1 + i));
        end
        @(posedge clk);
        #1;
        check_val("full_ready", 32'(req1_ready), 0);
        r_hold = 1'b0;
        req1_valid = 1'b1;
        req1_data = 8'h99;
        @(posedge clk);
        #1;
        check_val("full_pop_we", 32'(ser_we), 1);
        check_val("full_ready_back", 32'(req1_ready), 1);
        req1_valid = 1'b0;
        drain("full");

        // Reset in WAIT_ACK
        r_hold = 1'b1;
        do_reset();
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        push(1'b1, 8'h33);
        sb.push_back({1'b1, 1'b1, 8'h33});
        @(posedge clk);
        #1 r_hold = 1'b0;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!ser_we && guard < 10);
        check_val("mid_we", 32'(ser_we), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_we", 32'(ser_we), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_ready", 32'({req1_ready, req0_ready}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rel_ready", 32'({req1_ready, req0_ready}), 32'h3);
        check_val("mid_rel_locked", 32'(locked), 0);
        repeat (10) @(posedge clk);
        #1;
        check_val("mid_discard", 32'(sb.size()), 0);
        check_val("mid_idle", 32'({busy, ser_we}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: per-requester FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: idle cycles after which a line lock is dropped; minimum 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port `clk`, input, 1 bit: clock; all logic updates on the rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port `req0_valid`, input, 1 bit: requester 0 offers a byte.
REQ-007 SHALL have port `req0_data`, input, 8 bits: requester 0 byte.
REQ-008 SHALL have port `req0_ready`, output, 1 bit: requester 0 FIFO not full.
REQ-009 SHALL have ports `req1_valid`, `req1_data` and `req1_ready`: same as the req0 ports, for requester 1.
REQ-010 SHALL have port `ser_we`, output, 1 bit: write strobe to the byte serializer.
REQ-011 SHALL have port `ser_data`, output, 8 bits: byte to the serializer.
REQ-012 SHALL have port `ser_ready`, input, 1 bit: serializer idle. The serializer drops it the cycle after it accepts a write and raises it when the stop bit is done.
REQ-013 SHALL have port `owner`, output, 1 bit: requester currently owning the line lock, or last served.
REQ-014 SHALL have port `locked`, output, 1 bit: a line lock is held.
REQ-015 SHALL have port `busy`, output, 1 bit: high when state is not IDLE or either FIFO is non-empty.

Function
REQ-016 SHALL store each requester's bytes in its own DEPTH-entry FIFO.
- A push occurs when `reqN_valid` and `reqN_ready` are both high.
- `reqN_ready` = not full, and is combinational from the registered count.
REQ-017 SHALL perform both operations when a push and a pop hit the same FIFO in one cycle. The count is unchanged, and the pointers wrap modulo DEPTH.
REQ-018 SHALL accept no push on a full FIFO, even if a pop occurs in the same cycle. The freed slot is usable from the next cycle.
REQ-019 SHALL implement states IDLE, WAIT_ACK and WAIT_DONE.
REQ-020 SHALL select a requester in IDLE when `ser_ready` = 1 and a candidate exists, as follows:
- If `locked` is set and owner's FIFO is non-empty, select owner.
- Else if `locked` is set, select nothing.
- Else if exactly one FIFO is non-empty, select it.
- Else if both are non-empty, select the requester that is not `owner` (round-robin).
REQ-021 SHALL, on a selection, in that same edge:
- pop the head byte into `ser_data`;
- set `ser_we` = 1;
- set `owner` = the selected requester;
- go to WAIT_ACK.
REQ-022 SHALL update the lock at that edge: the lock is released if the byte equals 8'h0A, and set otherwise.
REQ-023 SHALL, in WAIT_ACK, when `ser_ready` = 0, set `ser_we` = 0 and go to WAIT_DONE. Otherwise it holds `ser_we` and `ser_data` stable.
REQ-024 SHALL, in WAIT_DONE, when `ser_ready` = 1, go to IDLE. The earliest next selection is one cycle later.
REQ-025 SHALL keep a lock timer that counts while locked, in IDLE, with owner's FIFO empty.
- The timer resets to 0 on any selection and whenever `locked` = 0.
- When it reaches LOCK_TIMEOUT, `locked` clears on that edge.
- It is sized $clog2(LOCK_TIMEOUT+1) bits and saturates.
REQ-026 SHALL NOT release the lock because the non-owner has pending data. The non-owner waits for a newline or the timeout.
REQ-027 SHALL NOT select anything while `ser_ready` = 0 in IDLE.

Reset
REQ-028 SHALL, while `rst` = 1, set:
- state = IDLE;
- FIFOs empty, with both pointers 0;
- `ser_we` = 0;
- `ser_data` = 8'h00;
- `owner` = 0, `locked` = 0;
- timer = 0.
REQ-029 SHALL hold `req0_ready` and `req1_ready` low while `rst` = 1, and high the cycle after reset deasserts.
REQ-030 SHALL abandon any transfer when reset is asserted mid-operation, including in WAIT_ACK with `ser_we` = 1. `ser_we` = 0 after that edge, and all queued bytes are discarded.

Verification
REQ-031 SHALL cover a single byte:
- Stimulus: push 8'h41 on req0 with the serializer model idle.
- Response: `ser_we` = 1 with `ser_data` = 8'h41 one cycle later; `locked` = 1; `owner` = 0; `ser_we` drops the cycle after `ser_ready` falls.
REQ-032 SHALL cover the line lock:
- Stimulus: req0 pushes "AB\n" while req1 pushes "xy".
- Response: serializer order is A, B, 0x0A, x, y; `locked` = 0 after 0x0A, then 1 after x.
REQ-033 SHALL cover round-robin:
- Stimulus: both FIFOs pre-loaded with 0x0A bytes, `owner` = 0.
- Response: grants alternate 1, 0, 1, 0.
REQ-034 SHALL cover the lock timeout:
- Stimulus: LOCK_TIMEOUT = 8; req0 sends 'A' then stops; req1 has 'z' pending.
- Response: 'z' is issued after exactly 8 empty-IDLE cycles plus 1.
REQ-035 SHALL cover full and simultaneous events:
- Stimulus: fill req1 to DEPTH while the serializer is stalled.
- Response: `req1_ready` = 0; a push in the pop cycle is dropped; ready returns the next cycle.
REQ-036 SHALL cover reset mid-transfer:
- Stimulus: assert `rst` in WAIT_ACK.
- Response: `ser_we` = 0, `busy` = 0, and `req0_ready` = `req1_ready` = 1 after release.
